// File: rtl/multicycle_chunk_adder_pkg.sv
// Shared types and helpers for the multi-cycle chunked adder.
`timescale 1ns/1ps
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } chunk_add_state_t;

  function automatic int unsigned num_chunks(input int unsigned dw, input int unsigned cw);
    return dw / cw;
  endfunction

endpackage

// File: rtl/multicycle_chunk_adder_if.sv
// Operand/result handshake bundle for multicycle_chunk_adder.
`timescale 1ns/1ps
interface multicycle_chunk_adder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] operand_A_i;
  logic [DATA_WIDTH-1:0] operand_B_i;
  logic                  carry_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  carry_o;
  logic                  overflow_o;
  logic                  valid_o;

  modport master (
    output operand_A_i, operand_B_i, carry_i, valid_i,
    input  ready_o, result_o, carry_o, overflow_o, valid_o
  );

  modport slave (
    input  operand_A_i, operand_B_i, carry_i, valid_i,
    output ready_o, result_o, carry_o, overflow_o, valid_o
  );
endinterface

// File: rtl/multicycle_chunk_adder_ripple_carry_adder.sv
// Combinational ripple-carry adder used for one chunk per cycle.
`timescale 1ns/1ps
module ripple_carry_adder #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = cin;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle adder: CHUNK_WIDTH bits per cycle through one narrow adder,
// carry registered between chunks, result shifted in from the MSB side.
`timescale 1ns/1ps
module multicycle_chunk_adder
  import adder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CHUNK_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  multicycle_chunk_adder_if.slave bus
);

  localparam int unsigned NUM_CHUNKS = num_chunks(DATA_WIDTH, CHUNK_WIDTH);
  localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_width_check
    $fatal(1, "DATA_WIDTH must be an integer multiple of CHUNK_WIDTH");
  end

  chunk_add_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]  a_sh, b_sh;
  logic [DATA_WIDTH-1:0]  result_q;
  logic [DATA_WIDTH-1:0]  res_next;
  logic                   carry_q;
  logic                   carry_out_q;
  logic                   overflow_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CHUNK_WIDTH-1:0] chunk_sum;
  logic                   chunk_cout;
  logic                   accept;
  logic                   last_chunk;

  assign accept     = (state_q == IDLE) && bus.valid_i;
  assign last_chunk = (cnt_q == LAST_CHUNK);

  ripple_carry_adder #(.DATA_WIDTH(CHUNK_WIDTH)) u_rca (
    .a    (a_sh[CHUNK_WIDTH-1:0]),
    .b    (b_sh[CHUNK_WIDTH-1:0]),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // Only the upper DATA_WIDTH-CHUNK_WIDTH bits of partial result need storage;
  // the final chunk is concatenated straight into the output register.
  if (NUM_CHUNKS == 1) begin : g_single
    assign res_next = chunk_sum;
  end else begin : g_multi
    logic [DATA_WIDTH-CHUNK_WIDTH-1:0] res_hi;

    assign res_next = {chunk_sum, res_hi};

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
        res_hi <= '0;
      else if (state_q == ADD)
        res_hi <= res_next[DATA_WIDTH-1:CHUNK_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.valid_i) state_d = ADD;
      ADD:     if (last_chunk)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_sh        <= '0;
      b_sh        <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      a_sh    <= bus.operand_A_i;
      b_sh    <= bus.operand_B_i;
      carry_q <= bus.carry_i;
      cnt_q   <= '0;
    end else if (state_q == ADD) begin
      a_sh    <= a_sh >> CHUNK_WIDTH;
      b_sh    <= b_sh >> CHUNK_WIDTH;
      carry_q <= chunk_cout;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_chunk) begin
        // The top chunk's operand MSBs sit at bit CHUNK_WIDTH-1 of the shift registers here.
        result_q    <= res_next;
        carry_out_q <= chunk_cout;
        overflow_q  <= chunk_cout ^ (a_sh[CHUNK_WIDTH-1] ^ b_sh[CHUNK_WIDTH-1] ^ chunk_sum[CHUNK_WIDTH-1]);
      end
    end
  end

  assign bus.ready_o    = (state_q == IDLE);
  assign bus.valid_o    = (state_q == DONE);
  assign bus.result_o   = result_q;
  assign bus.carry_o    = carry_out_q;
  assign bus.overflow_o = overflow_q;

endmodule
